// File: rtl/grf_write_queue_if.sv
// Bundle of the producer handshake, GRF write-port outputs and forwarding
// lookup signals of grf_write_queue. The queue uses the slave modport; the
// producer/GRF/forwarding side uses the master modport.
interface grf_write_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // producer request
  logic          InValid;
  logic          InReady;
  logic [4:0]    InReg;
  logic [31:0]   InData;
  logic [31:0]   InPC;
  // retire control and GRF write port
  logic          Hold;
  logic          WriteEnable;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic [31:0]   PC;
  // forwarding lookup
  logic [4:0]    LookupAddr;
  logic          LookupHit;
  logic [31:0]   LookupData;
  // occupancy
  logic [CW-1:0] Count;

  modport master (
    output InValid, InReg, InData, InPC, Hold, LookupAddr,
    input  InReady, WriteEnable, WriteRegister, WriteData, PC,
           LookupHit, LookupData, Count
  );

  modport slave (
    input  InValid, InReg, InData, InPC, Hold, LookupAddr,
    output InReady, WriteEnable, WriteRegister, WriteData, PC,
           LookupHit, LookupData, Count
  );
endinterface

// File: rtl/grf_write_queue.sv
// In-order write buffer in front of the GRF write port. Accepts register
// writes over valid/ready, retires one per cycle unless Hold is set, and
// offers a combinational youngest-match lookup for forwarding.
// Optional macro GRF_WRITE_QUEUE_TRACE_EN: prints a GRF-style trace line at
// every retire edge.
module grf_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  grf_write_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  ptr_t          rd_ptr;
  ptr_t          wr_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Register 0 requests finish the handshake but are never stored.
  assign push  = bus.InValid && !full && (bus.InReg != 5'd0);
  assign pop   = !empty && !bus.Hold;

  assign bus.InReady       = !full;
  assign bus.WriteEnable   = pop;
  assign bus.WriteRegister = empty ? 5'd0  : reg_mem[rd_ptr];
  assign bus.WriteData     = empty ? 32'd0 : data_mem[rd_ptr];
  assign bus.PC            = empty ? 32'd0 : pc_mem[rd_ptr];
  assign bus.Count         = count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage written at the tail on each accepted push.
  // NOTE: payload storage is not reset; validity comes solely from count
  // and the pointers, so stale contents are never observable.
  always_ff @(posedge Clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= bus.InReg;
      data_mem[wr_ptr] <= bus.InData;
      pc_mem[wr_ptr]   <= bus.InPC;
    end
  end

  // Forwarding lookup: walk stored entries oldest to youngest so the last
  // match (the youngest) wins.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on the no-hit path.
  always_comb begin
    ptr_t idx;
    bus.LookupHit  = 1'b0;
    bus.LookupData = 32'd0;
    idx            = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((CW'(i) < count) && (bus.LookupAddr != 5'd0) &&
          (reg_mem[idx] == bus.LookupAddr)) begin
        bus.LookupHit  = 1'b1;
        bus.LookupData = data_mem[idx];
      end
    end
  end

`ifdef GRF_WRITE_QUEUE_TRACE_EN
  // Retire trace in the GRF's own format.
  always @(posedge Clk) begin
    if (Rst && bus.WriteEnable)
      $display("@%h: $%d <= %h", bus.PC, bus.WriteRegister, bus.WriteData);
  end
`else
`endif

endmodule

// File: doc/grf_write_queue.md
# grf_write_queue

Write-side buffer in front of the GRF write port. Accepts register write requests (register number, data, PC) from the writeback stage and multi-cycle units over a valid/ready handshake, holds them in a small in-order queue, and retires exactly one per cycle onto the GRF's WriteEnable/WriteRegister/WriteData/PC inputs. It also answers a combinational lookup so forwarding logic can read pending, not-yet-written values.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  reset, asynchronous, active-low; clears all state
- InValid  input  1  producer has a write request
- InReady  output  1  queue can accept; equals !full
- InReg  input  5  destination register
- InData  input  32  write data
- InPC  input  32  PC of producing instruction
- Hold  input  1  when 1, no entry retires this cycle
- WriteEnable  output  1  to GRF; 1 when queue non-empty and Hold=0
- WriteRegister  output  5  to GRF; head entry register
- WriteData  output  32  to GRF; head entry data
- PC  output  32  to GRF; head entry PC
- LookupAddr  input  5  register queried by forwarding logic
- LookupHit  output  1  a pending entry targets LookupAddr
- LookupData  output  32  data of youngest matching pending entry
- Count  output  log2(DEPTH)+1  entries currently held

## Operation
- Circular buffer: read pointer, write pointer, occupancy counter of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Push: InValid & InReady at a rising edge. Requests with InReg=0 complete the handshake but are discarded (not stored, Count unchanged).
- Pop: WriteEnable=1 at a rising edge; the head is retired and the read pointer advances. GRF samples the same edge.
- Outputs WriteRegister/WriteData/PC are combinational from the head entry; when empty they drive 0 and WriteEnable=0.
- Simultaneous push and pop: both occur; Count unchanged. Allowed when full? No: InReady=!full, computed from current occupancy only, with no pass-through.
- Order preserved: entries retire strictly in push order, so two writes to one register reach the GRF oldest first.
- Lookup: scans only stored entries; LookupHit=1 if any entry has register LookupAddr; LookupData is the youngest such entry's data; LookupAddr=0 never hits; no hit → LookupData=0. The request being pushed in the same cycle is not visible until after the edge.
- Hold=1: queue keeps accepting until full; contents and head unchanged.

## Timing
- Reset (Rst=0): immediately Count=0, InReady=1, WriteEnable=0, WriteRegister=0, WriteData=0, PC=0, LookupHit=0, LookupData=0. Reset mid-operation drops all pending entries; none reach the GRF.
- Latency: request pushed at edge N into empty queue → WriteEnable=1 during cycle N..N+1, GRF written at edge N+1 (if Hold=0).
- Throughput: one push and one retire per cycle sustained.
- Full (Count=DEPTH): InReady=0 until a pop edge; InReady rises the cycle after the pop.
- Empty: Count=0, WriteEnable=0 regardless of Hold.

## Configuration
- GRF_WRITE_QUEUE_TRACE_EN defined: at every pop edge, print "@%h: $%d <= %h" with PC, WriteRegister, WriteData (same format as the GRF trace, so the GRF's own print can be disabled). Not defined: no simulation output; RTL otherwise identical.

## Test plan
- Reset then push (reg 5, 0x1234, PC 0x3000) with Hold=0 → next cycle WriteEnable=1, WriteRegister=5, WriteData=0x00001234, PC=0x00003000; Count returns to 0 after following edge.
- Hold=1, push DEPTH=4 requests regs 1..4 → InReady=0, Count=4; fifth request stalls; release Hold → four retires in order 1,2,3,4 on consecutive edges.
- Push reg 7=0xA then reg 7=0xB while held → LookupAddr=7 gives LookupHit=1, LookupData=0xB; after both retire LookupHit=0.
- Push InReg=0 data 0xFFFF → InReady=1 handshake completes, Count stays 0, WriteEnable never asserts.
- Full queue, push and pop in same cycle sequence → no entry lost or duplicated over 20 random-data cycles; retire order matches push order.
- Assert Rst=0 mid-cycle with 3 pending → outputs go to reset values without a clock edge; after release, no stale write appears.
